// File: rtl/dual_port_ram_arbiter_if.sv
// +-----------------------------------------------------------------------------+
// | dual_port_ram_arbiter_if : two Wishbone request ports plus two macro banks |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface dual_port_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
  logic [1:0][ADDR_WIDTH-1:0] wb_addr_i;
  logic [1:0][DATA_WIDTH-1:0] wb_data_i;
  logic [1:0][SEL_WIDTH-1:0]  wb_sel_i;
  logic [1:0]                 wb_we_i;
  logic [1:0]                 wb_stb_i;
  logic [1:0]                 wb_stall_o;
  logic [1:0]                 wb_ack_o;
  logic [1:0][DATA_WIDTH-1:0] wb_data_o;
  logic [1:0]                 mem_en_o;
  logic [1:0]                 mem_we_o;
  logic [1:0][SEL_WIDTH-1:0]  mem_wmask_o;
  logic [1:0][ADDR_WIDTH-2:0] mem_addr_o;
  logic [1:0][DATA_WIDTH-1:0] mem_din_o;
  logic [1:0][DATA_WIDTH-1:0] mem_dout_i;
  logic [15:0]                conflict_cnt_o;

  modport slave (
    input  wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_stb_i, mem_dout_i,
    output wb_stall_o, wb_ack_o, wb_data_o, mem_en_o, mem_we_o, mem_wmask_o,
           mem_addr_o, mem_din_o, conflict_cnt_o
  );

  modport master (
    output wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_stb_i, mem_dout_i,
    input  wb_stall_o, wb_ack_o, wb_data_o, mem_en_o, mem_we_o, mem_wmask_o,
           mem_addr_o, mem_din_o, conflict_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/dual_port_ram_arbiter.sv
// +-----------------------------------------------------------------------------+
// | dual_port_ram_arbiter : routes two Wishbone ports onto two RAM banks with  |
// | per-bank alternating priority on conflicts.                   Rev 1.0      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module dual_port_ram_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  dual_port_ram_arbiter_if.slave  bus
);

  logic [1:0]  w_bank;
  logic [1:0]  w_grant;
  logic        w_conflict;
  logic        w_winner;
  logic [1:0]  r_prio;
  logic [1:0]  r_ack;
  logic [1:0]  r_rd;
  logic [1:0]  r_bank;
  logic [15:0] r_cnt;

  logic [1:0]                 w_mem_en;
  logic [1:0]                 w_mem_we;
  logic [1:0][SEL_WIDTH-1:0]  w_mem_wmask;
  logic [1:0][ADDR_WIDTH-2:0] w_mem_addr;
  logic [1:0][DATA_WIDTH-1:0] w_mem_din;
  logic [1:0][DATA_WIDTH-1:0] w_wb_data;

  always_comb begin
    w_bank[0]  = bus.wb_addr_i[0][ADDR_WIDTH-1];
    w_bank[1]  = bus.wb_addr_i[1][ADDR_WIDTH-1];
    w_conflict = !rst && bus.wb_stb_i[0] && bus.wb_stb_i[1] && (w_bank[0] == w_bank[1]);
    w_winner   = r_prio[w_bank[0]];
    w_grant    = 2'b00;
    if (!rst) begin
      if (w_conflict) begin
        w_grant[w_winner] = 1'b1;
      end else begin
        w_grant = bus.wb_stb_i;
      end
    end
  end

  // A bank is never granted to both ports, so port B owning it identifies the source.
  generate
    for (genvar k = 0; k < 2; k++) begin : g_bank
      logic w_hit_a;
      logic w_hit_b;
      assign w_hit_a        = w_grant[0] && (w_bank[0] == 1'(k));
      assign w_hit_b        = w_grant[1] && (w_bank[1] == 1'(k));
      assign w_mem_en[k]    = w_hit_a | w_hit_b;
      assign w_mem_we[k]    = w_hit_b ? bus.wb_we_i[1] : (w_hit_a ? bus.wb_we_i[0] : 1'b0);
      assign w_mem_wmask[k] = w_hit_b ? bus.wb_sel_i[1] : (w_hit_a ? bus.wb_sel_i[0] : '0);
      assign w_mem_addr[k]  = w_hit_b ? bus.wb_addr_i[1][ADDR_WIDTH-2:0] :
                              (w_hit_a ? bus.wb_addr_i[0][ADDR_WIDTH-2:0] : '0);
      assign w_mem_din[k]   = w_hit_b ? bus.wb_data_i[1] : (w_hit_a ? bus.wb_data_i[0] : '0);
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
      assign w_wb_data[p] = (r_ack[p] && r_rd[p]) ? bus.mem_dout_i[r_bank[p]] : '0;
    end
  endgenerate

  assign bus.mem_en_o       = w_mem_en;
  assign bus.mem_we_o       = w_mem_we;
  assign bus.mem_wmask_o    = w_mem_wmask;
  assign bus.mem_addr_o     = w_mem_addr;
  assign bus.mem_din_o      = w_mem_din;
  assign bus.wb_stall_o     = bus.wb_stb_i & ~w_grant;
  assign bus.wb_ack_o       = r_ack;
  assign bus.wb_data_o      = w_wb_data;
  assign bus.conflict_cnt_o = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack  <= 2'b00;
      r_rd   <= 2'b00;
      r_bank <= 2'b00;
      r_prio <= 2'b00;
      r_cnt  <= 16'h0000;
    end else begin
      r_ack  <= w_grant;
      r_rd   <= w_grant & ~bus.wb_we_i;
      r_bank <= w_bank;
      if (w_conflict) begin
        // Hand the bank to the loser next time so nobody stalls twice in a row.
        r_prio[w_bank[0]] <= ~w_winner;
        if (r_cnt != 16'hFFFF) begin
          r_cnt <= r_cnt + 16'h0001;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_dual_port_ram_arbiter : directed vector bench with a two-bank RAM model  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_dual_port_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dual_port_ram_arbiter_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .SEL_WIDTH(4)) bus ();

  dual_port_ram_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM macro model: byte-masked writes, read data registered one cycle.
  logic [31:0]      mem [2][256];
  logic [1:0][31:0] mdout;
  assign bus.mem_dout_i = mdout;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bus.mem_en_o[k]) begin
        if (bus.mem_we_o[k]) begin
          for (int b = 0; b < 4; b++)
            if (bus.mem_wmask_o[k][b])
              mem[k][bus.mem_addr_o[k]][8*b +: 8] <= bus.mem_din_o[k][8*b +: 8];
        end else begin
          mdout[k] <= mem[k][bus.mem_addr_o[k]];
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  stb;
    logic [1:0]  we;
    logic [8:0]  a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic [8:0]  a1;
    logic [31:0] d1;
    logic [3:0]  s1;
    logic [1:0]  e_stall;
    logic [1:0]  e_en;
    logic [3:0]  e_wm0;
    logic [3:0]  e_wm1;
    logic [1:0]  e_ack;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [14];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] stb, input logic [1:0] we,
    input logic [8:0] a0, input logic [31:0] d0, input logic [3:0] s0,
    input logic [8:0] a1, input logic [31:0] d1, input logic [3:0] s1,
    input logic [1:0] e_stall, input logic [1:0] e_en,
    input logic [3:0] e_wm0, input logic [3:0] e_wm1, input logic [1:0] e_ack,
    input logic [31:0] e_rd0, input logic [31:0] e_rd1, input logic [15:0] e_cnt);
    vec_t v;
    v.stb = stb; v.we = we; v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.a1 = a1; v.d1 = d1; v.s1 = s1; v.e_stall = e_stall; v.e_en = e_en;
    v.e_wm0 = e_wm0; v.e_wm1 = e_wm1; v.e_ack = e_ack;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic [1:0] stb, input logic [1:0] we,
                       input logic [8:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                       input logic [8:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    bus.wb_stb_i = stb; bus.wb_we_i = we;
    bus.wb_addr_i[0] = a0; bus.wb_data_i[0] = d0; bus.wb_sel_i[0] = s0;
    bus.wb_addr_i[1] = a1; bus.wb_data_i[1] = d1; bus.wb_sel_i[1] = s1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 9'h0, 32'h0, 4'h0, 9'h0, 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    check("rst_ack", {30'd0, bus.wb_ack_o}, 32'd0);
    check("rst_cnt", {16'd0, bus.conflict_cnt_o}, 32'd0);
    check("rst_data", bus.wb_data_o[0] | bus.wb_data_o[1], 32'd0);
    check("rst_mem", {bus.mem_en_o, bus.mem_we_o, bus.mem_wmask_o, bus.mem_addr_o} |
                     bus.mem_din_o[0] | bus.mem_din_o[1], 32'd0);
    tick();
    rst = 1'b0;
  endtask

  int stall_run [2];
  int stall_max;

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++)
        mem[k][i] = 32'h0;
    mdout = '0;

    vecs[0]  = mk(2'b00, 2'b00, 9'h000, 32'h0, 4'h0, 9'h000, 32'h0, 4'h0,
                  2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 32'h0, 32'h0, 16'd0);
    vecs[1]  = mk(2'b11, 2'b11, 9'h000, 32'hDEADBEEF, 4'hF, 9'h100, 32'hFACEFACE, 4'hF,
                  2'b00, 2'b11, 4'hF, 4'hF, 2'b11, 32'h0, 32'h0, 16'd0);
    vecs[2]  = mk(2'b11, 2'b00, 9'h000, 32'h0, 4'hF, 9'h100, 32'h0, 4'hF,
                  2'b00, 2'b11, 4'hF, 4'hF, 2'b11, 32'hDEADBEEF, 32'hFACEFACE, 16'd0);
    vecs[3]  = mk(2'b11, 2'b11, 9'h010, 32'hAAAA1234, 4'hF, 9'h011, 32'hBBBB5678, 4'hF,
                  2'b10, 2'b01, 4'hF, 4'h0, 2'b01, 32'h0, 32'h0, 16'd1);
    vecs[4]  = mk(2'b10, 2'b10, 9'h000, 32'h0, 4'h0, 9'h011, 32'hBBBB5678, 4'hF,
                  2'b00, 2'b01, 4'hF, 4'h0, 2'b10, 32'h0, 32'h0, 16'd1);
    vecs[5]  = mk(2'b11, 2'b00, 9'h010, 32'h0, 4'hF, 9'h011, 32'h0, 4'hF,
                  2'b01, 2'b01, 4'hF, 4'h0, 2'b10, 32'h0, 32'hBBBB5678, 16'd2);
    vecs[6]  = mk(2'b01, 2'b00, 9'h010, 32'h0, 4'hF, 9'h000, 32'h0, 4'h0,
                  2'b00, 2'b01, 4'hF, 4'h0, 2'b01, 32'hAAAA1234, 32'h0, 16'd2);
    vecs[7]  = mk(2'b01, 2'b01, 9'h020, 32'hFFFFFFFF, 4'hF, 9'h000, 32'h0, 4'h0,
                  2'b00, 2'b01, 4'hF, 4'h0, 2'b01, 32'h0, 32'h0, 16'd2);
    vecs[8]  = mk(2'b01, 2'b01, 9'h020, 32'h12345678, 4'h3, 9'h000, 32'h0, 4'h0,
                  2'b00, 2'b01, 4'h3, 4'h0, 2'b01, 32'h0, 32'h0, 16'd2);
    vecs[9]  = mk(2'b10, 2'b00, 9'h000, 32'h0, 4'h0, 9'h020, 32'h0, 4'hF,
                  2'b00, 2'b01, 4'hF, 4'h0, 2'b10, 32'h0, 32'hFFFF5678, 16'd2);
    vecs[10] = mk(2'b11, 2'b00, 9'h100, 32'h0, 4'hF, 9'h1FF, 32'h0, 4'hF,
                  2'b10, 2'b10, 4'h0, 4'hF, 2'b01, 32'hFACEFACE, 32'h0, 16'd3);
    vecs[11] = mk(2'b10, 2'b10, 9'h000, 32'h0, 4'h0, 9'h1FF, 32'h01020304, 4'hF,
                  2'b00, 2'b10, 4'h0, 4'hF, 2'b10, 32'h0, 32'h0, 16'd3);
    vecs[12] = mk(2'b11, 2'b00, 9'h1FF, 32'h0, 4'hF, 9'h100, 32'h0, 4'hF,
                  2'b01, 2'b10, 4'h0, 4'hF, 2'b10, 32'h0, 32'hFACEFACE, 16'd4);
    vecs[13] = mk(2'b01, 2'b00, 9'h1FF, 32'h0, 4'hF, 9'h000, 32'h0, 4'h0,
                  2'b00, 2'b10, 4'h0, 4'hF, 2'b01, 32'h01020304, 32'h0, 16'd4);

    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].stb, vecs[i].we, vecs[i].a0, vecs[i].d0, vecs[i].s0,
            vecs[i].a1, vecs[i].d1, vecs[i].s1);
      #1;
      check($sformatf("v%0d_stall", i), {30'd0, bus.wb_stall_o}, {30'd0, vecs[i].e_stall});
      check($sformatf("v%0d_en", i), {30'd0, bus.mem_en_o}, {30'd0, vecs[i].e_en});
      check($sformatf("v%0d_wm0", i), {28'd0, bus.mem_wmask_o[0]}, {28'd0, vecs[i].e_wm0});
      check($sformatf("v%0d_wm1", i), {28'd0, bus.mem_wmask_o[1]}, {28'd0, vecs[i].e_wm1});
      tick();
      check($sformatf("v%0d_ack", i), {30'd0, bus.wb_ack_o}, {30'd0, vecs[i].e_ack});
      check($sformatf("v%0d_rd0", i), bus.wb_data_o[0], vecs[i].e_rd0);
      check($sformatf("v%0d_rd1", i), bus.wb_data_o[1], vecs[i].e_rd1);
      check($sformatf("v%0d_cnt", i), {16'd0, bus.conflict_cnt_o}, {16'd0, vecs[i].e_cnt});
    end

    // Fairness: continuous bank-0 contention, winners alternate A, B, A, ...
    do_reset();
    stall_run[0] = 0; stall_run[1] = 0; stall_max = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 2'b00, 9'h010, 32'h0, 4'hF, 9'h011, 32'h0, 4'hF);
      #1;
      check($sformatf("fair%0d_stall", i), {30'd0, bus.wb_stall_o},
            (i % 2 == 0) ? 32'd2 : 32'd1);
      for (int p = 0; p < 2; p++) begin
        stall_run[p] = bus.wb_stall_o[p] ? stall_run[p] + 1 : 0;
        if (stall_run[p] > stall_max) stall_max = stall_run[p];
      end
      tick();
      check($sformatf("fair%0d_ack", i), {30'd0, bus.wb_ack_o},
            (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("fair%0d_data", i),
            (i % 2 == 0) ? bus.wb_data_o[0] : bus.wb_data_o[1],
            (i % 2 == 0) ? 32'hAAAA1234 : 32'hBBBB5678);
      check($sformatf("fair%0d_cnt", i), {16'd0, bus.conflict_cnt_o}, i + 1);
    end
    check("fair_max_stall", stall_max, 32'd1);

    // Reset mid-operation: bank-0 priority is left pointing at B, reset must restore A.
    drive(2'b11, 2'b11, 9'h030, 32'h11111111, 4'hF, 9'h031, 32'h22222222, 4'hF);
    tick();
    drive(2'b01, 2'b01, 9'h040, 32'h33333333, 4'hF, 9'h000, 32'h0, 4'h0);
    rst = 1'b1;
    #1;
    check("midrst_stall", {30'd0, bus.wb_stall_o}, 32'd1);
    check("midrst_en", {30'd0, bus.mem_en_o}, 32'd0);
    tick();
    drive(2'b00, 2'b00, 9'h0, 32'h0, 4'h0, 9'h0, 32'h0, 4'h0);
    #1;
    check("midrst_ack", {30'd0, bus.wb_ack_o}, 32'd0);
    check("midrst_cnt", {16'd0, bus.conflict_cnt_o}, 32'd0);
    rst = 1'b0;
    drive(2'b11, 2'b00, 9'h010, 32'h0, 4'hF, 9'h011, 32'h0, 4'hF);
    #1;
    check("postrst_win_a", {30'd0, bus.wb_stall_o}, 32'd2);
    tick();
    check("postrst_ack", {30'd0, bus.wb_ack_o}, 32'd1);
    check("postrst_cnt", {16'd0, bus.conflict_cnt_o}, 32'd1);

    // Counter saturation under permanent bank-1 contention.
    do_reset();
    drive(2'b11, 2'b00, 9'h100, 32'h0, 4'hF, 9'h101, 32'h0, 4'hF);
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", {16'd0, bus.conflict_cnt_o}, 32'h0000FFFE);
    tick();
    check("sat_ffff", {16'd0, bus.conflict_cnt_o}, 32'h0000FFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold", {16'd0, bus.conflict_cnt_o}, 32'h0000FFFF);
    drive(2'b00, 2'b00, 9'h0, 32'h0, 4'h0, 9'h0, 32'h0, 4'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
